uart_tx_serializer: RTL and testbench

// - Transmit-side bit engine of the APB UART; the inverse of the receive path's edge/start-bit detection.
// - Takes a parallel character plus line-control settings and drives the serial line SOUT.
// - Frame: start bit, 5..8 data bits LSB first, optional parity, 1/1.5/2 stop bits.
// - Bit timing comes from a 16x oversample enable (TXCLK) supplied by the baud generator.

---
 rtl/uart_tx_serializer_pkg.sv | 24 ++
 rtl/uart_tx_serializer_tick_cnt.sv | 30 +++
 rtl/uart_tx_serializer.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_serializer_pkg.sv
// Shared definitions for the UART transmit path: FSM states, word-length
// encodings and the oversample default.
package uart_tx_serializer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } tx_state_t;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  localparam int OVERSAMPLE_DEF = 16;

  function automatic logic [3:0] wordlen(input logic [1:0] wls);
    return 4'd5 + {2'b00, wls};
  endfunction

endpackage

// File: rtl/uart_tx_serializer_tick_cnt.sv
// Oversample tick counter: counts TXCLK enables within one bit period and
// flags the last tick of a full bit and of a half bit.
module uart_tx_tick_cnt #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic bit_end,
  output logic half_end
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);

  logic [CW-1:0] cnt;

  // OVERSAMPLE is a power of two, so the natural wrap returns the count to 0
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + CW'(1);
  end

  assign bit_end  = en && (cnt == LAST);
  assign half_end = en && (cnt == HALF);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit bit engine: frames a parallel character (start, 5..8 data
// bits LSB first, optional parity, 1/1.5/2 stop bits) onto SOUT.
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_MAX   = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                TXCLK,
  input  logic                TXSTART,
  input  logic                CLEAR,
  input  logic [DATA_MAX-1:0] DIN,
  input  logic [1:0]          WLS,
  input  logic                STB,
  input  logic                PEN,
  input  logic                EPS,
  input  logic                SP,
  input  logic                BC,
  output logic                SOUT,
  output logic                TXFINISHED
);

  function automatic logic parity_bit(input logic [DATA_MAX-1:0] d,
                                      input logic [1:0] wls,
                                      input logic eps,
                                      input logic sp);
    logic x;
    x = 1'b0;
    for (int i = 0; i < DATA_MAX; i++)
      if (i < int'(wordlen(wls))) x ^= d[i];
    if (sp) return ~eps;
    return eps ? x : ~x;
  endfunction

  tx_state_t           state, state_n;
  logic [DATA_MAX-1:0] shreg, shreg_n;
  logic [3:0]          idx, idx_n;
  logic                stop_ph, stop_n;
  logic                done_n;
  logic                sout_n;
  logic                level;
  logic                cnt_clr;
  logic                latch;
  logic                bit_end, half_end;

  logic [1:0]          wls_q;
  logic                stb_q, pen_q, par_q;
  logic [3:0]          wlen;

  assign wlen = wordlen(wls_q);

  uart_tx_tick_cnt #(.OVERSAMPLE(OVERSAMPLE)) u_tick (
    .clk      (CLK),
    .rst      (RST),
    .en       (TXCLK),
    .clr      (cnt_clr),
    .bit_end  (bit_end),
    .half_end (half_end)
  );

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    idx_n   = idx;
    stop_n  = stop_ph;
    done_n  = 1'b0;
    cnt_clr = 1'b0;
    latch   = 1'b0;
    if (CLEAR) begin
      state_n = IDLE;
      idx_n   = '0;
      stop_n  = 1'b0;
      cnt_clr = 1'b0 | 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // Holding the counter clear here also discards a TXCLK coincident with TXSTART
          cnt_clr = 1'b1;
          if (TXSTART) begin
            latch   = 1'b1;
            state_n = START;
            shreg_n = DIN;
            idx_n   = '0;
            stop_n  = 1'b0;
          end
        end
        START: if (bit_end) state_n = DATA;
        DATA: begin
          if (bit_end) begin
            shreg_n = shreg >> 1;
            if (idx == wlen - 4'd1) begin
              idx_n   = '0;
              state_n = pen_q ? PAR : STOP;
            end else begin
              idx_n = idx + 4'd1;
            end
          end
        end
        PAR: if (bit_end) state_n = STOP;
        STOP: begin
          if (!stop_ph) begin
            if (bit_end) begin
              if (stb_q) begin
                stop_n = 1'b1;
              end else begin
                state_n = IDLE;
                done_n  = 1'b1;
              end
            end
          end else if ((wls_q == WLS_5) ? half_end : bit_end) begin
            // Second stop period: half a bit for 5-bit words, else a full bit
            state_n = IDLE;
            stop_n  = 1'b0;
            done_n  = 1'b1;
            cnt_clr = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    case (state_n)
      START:   level = 1'b0;
      DATA:    level = shreg_n[0];
      PAR:     level = par_q;
      default: level = 1'b1;
    endcase
    sout_n = BC ? 1'b0 : level;
  end

  // Control and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      shreg      <= '0;
      idx        <= '0;
      stop_ph    <= 1'b0;
      SOUT       <= 1'b1;
      TXFINISHED <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      idx        <= idx_n;
      stop_ph    <= stop_n;
      SOUT       <= sout_n;
      TXFINISHED <= done_n;
    end
  end

  // Frame configuration captured at start so mid-frame changes are ignored
  always_ff @(posedge CLK) begin
    if (latch) begin
      wls_q <= WLS;
      stb_q <= STB;
      pen_q <= PEN;
      par_q <= parity_bit(DIN, WLS, EPS, SP);
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: table of hand-computed frames plus
// sequences for clear, reset, break, back-to-back and sparse TXCLK.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst, txclk, txstart, clear, stb, pen, eps, sp, bc;
  logic [7:0] din;
  logic [1:0] wls;
  logic       sout, txfinished;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_serializer dut (
    .CLK        (clk),
    .RST        (rst),
    .TXCLK      (txclk),
    .TXSTART    (txstart),
    .CLEAR      (clear),
    .DIN        (din),
    .WLS        (wls),
    .STB        (stb),
    .PEN        (pen),
    .EPS        (eps),
    .SP         (sp),
    .BC         (bc),
    .SOUT       (sout),
    .TXFINISHED (txfinished)
  );

  // bits[i] is the i-th transmitted level (start, data LSB first, parity)
  typedef struct {
    logic [7:0]  din;
    logic [1:0]  wls;
    logic        stb, pen, eps, sp;
    logic [11:0] bits;
    int          nb;
    int          stop;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_level(input vec_t v, input int c);
    if (c <= v.nb * 16) return v.bits[(c - 1) / 16];
    return 1'b1;
  endfunction

  task automatic apply_cfg(input vec_t v);
    din = v.din; wls = v.wls; stb = v.stb; pen = v.pen; eps = v.eps; sp = v.sp;
  endtask

  task automatic scramble_cfg(input vec_t v);
    din = ~v.din; wls = ~v.wls; stb = ~v.stb; pen = ~v.pen; eps = ~v.eps; sp = ~v.sp;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic ok;
    int   c;
    apply_cfg(v);
    txstart = 1'b1;
    @(posedge clk); #1;
    txstart = 1'b0;
    c = 0;
    for (int b = 0; b < v.nb; b++) begin
      ok = 1'b1;
      for (int t = 0; t < 16; t++) begin
        @(negedge clk);
        c++;
        if (sout !== v.bits[b] || txfinished !== 1'b0) ok = 1'b0;
        if (c == 20) scramble_cfg(v);
      end
      check($sformatf("%s_bit%0d", tag, b), {31'd0, ok}, 32'd1);
    end
    ok = 1'b1;
    for (int t = 0; t < v.stop; t++) begin
      @(negedge clk);
      if (sout !== 1'b1 || txfinished !== 1'b0) ok = 1'b0;
    end
    check($sformatf("%s_stop", tag), {31'd0, ok}, 32'd1);
    @(negedge clk);
    check($sformatf("%s_fin", tag), {31'd0, txfinished}, 32'd1);
    @(negedge clk);
    check($sformatf("%s_fin_end", tag), {30'd0, txfinished, sout}, 32'd1);
  endtask

  initial begin
    logic ok_a, ok_b;
    int   fin_cnt, fin1, fin2, c;

    vecs[0] = '{din: 8'h55, wls: 2'b11, stb: 1'b0, pen: 1'b0, eps: 1'b0, sp: 1'b0, bits: 12'h0AA, nb: 9,  stop: 16};
    vecs[1] = '{din: 8'hE3, wls: 2'b00, stb: 1'b1, pen: 1'b1, eps: 1'b1, sp: 1'b0, bits: 12'h006, nb: 7,  stop: 24};
    vecs[2] = '{din: 8'h7F, wls: 2'b10, stb: 1'b0, pen: 1'b1, eps: 1'b0, sp: 1'b1, bits: 12'h1FE, nb: 9,  stop: 16};
    vecs[3] = '{din: 8'hA5, wls: 2'b11, stb: 1'b1, pen: 1'b1, eps: 1'b0, sp: 1'b0, bits: 12'h34A, nb: 10, stop: 32};
    vecs[4] = '{din: 8'hFF, wls: 2'b01, stb: 1'b0, pen: 1'b1, eps: 1'b1, sp: 1'b0, bits: 12'h07E, nb: 8,  stop: 16};
    vecs[5] = '{din: 8'h1A, wls: 2'b00, stb: 1'b0, pen: 1'b0, eps: 1'b0, sp: 1'b0, bits: 12'h034, nb: 6,  stop: 16};

    rst = 1'b1; txclk = 1'b1; txstart = 1'b0; clear = 1'b0; bc = 1'b0;
    apply_cfg(vecs[0]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_sout", {31'd0, sout}, 32'd1);
    check("reset_fin", {31'd0, txfinished}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_sout", {31'd0, sout}, 32'd1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // CLEAR in the middle of data bit 1
    apply_cfg(vecs[0]);
    txstart = 1'b1;
    @(posedge clk); #1;
    txstart = 1'b0;
    for (int k = 1; k <= 40; k++) @(negedge clk);
    check("clr_pre", {31'd0, sout}, 32'd0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_sout", {31'd0, sout}, 32'd1);
    ok_a = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sout !== 1'b1 || txfinished !== 1'b0) ok_a = 1'b0;
    end
    check("clr_quiet", {31'd0, ok_a}, 32'd1);
    run_vec(vecs[0], "after_clr");

    // Reset mid-frame
    apply_cfg(vecs[3]);
    txstart = 1'b1;
    @(posedge clk); #1;
    txstart = 1'b0;
    for (int k = 1; k <= 40; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_sout", {31'd0, sout}, 32'd1);
    ok_a = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sout !== 1'b1 || txfinished !== 1'b0) ok_a = 1'b0;
    end
    check("rst_mid_quiet", {31'd0, ok_a}, 32'd1);

    // Break during data: low for cycles 31..50, frame otherwise unchanged
    apply_cfg(vecs[0]);
    txstart = 1'b1;
    @(posedge clk); #1;
    txstart = 1'b0;
    ok_a = 1'b1; ok_b = 1'b1;
    for (int k = 1; k <= 160; k++) begin
      @(negedge clk);
      if (k >= 31 && k <= 50) begin
        if (sout !== 1'b0) ok_a = 1'b0;
      end else if (sout !== exp_level(vecs[0], k) || txfinished !== 1'b0) begin
        ok_b = 1'b0;
      end
      if (k == 30) bc = 1'b1;
      if (k == 50) bc = 1'b0;
    end
    check("bc_low", {31'd0, ok_a}, 32'd1);
    check("bc_restore", {31'd0, ok_b}, 32'd1);
    @(negedge clk);
    check("bc_fin", {31'd0, txfinished}, 32'd1);
    @(negedge clk);

    // TXSTART held high: frames back-to-back
    apply_cfg(vecs[0]);
    txstart = 1'b1;
    @(posedge clk); #1;
    fin_cnt = 0; fin1 = 0; fin2 = 0;
    for (int k = 1; k <= 322; k++) begin
      @(negedge clk);
      if (txfinished === 1'b1) begin
        fin_cnt++;
        if (fin_cnt == 1) fin1 = k;
        if (fin_cnt == 2) fin2 = k;
      end
      if (k == 161) check("b2b_stop_lvl", {31'd0, sout}, 32'd1);
      if (k == 162) check("b2b_start_bit", {31'd0, sout}, 32'd0);
      if (k == 322) txstart = 1'b0;
    end
    check("b2b_fin_cnt", fin_cnt, 32'd2);
    check("b2b_fin1", fin1, 32'd161);
    check("b2b_fin2", fin2, 32'd322);
    ok_a = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sout !== 1'b1 || txfinished !== 1'b0) ok_a = 1'b0;
    end
    check("b2b_idle_after", {31'd0, ok_a}, 32'd1);

    // TXCLK only on even cycles: 160 ticks end at cycle 320
    apply_cfg(vecs[0]);
    txclk = 1'b0;
    txstart = 1'b1;
    @(posedge clk); #1;
    txstart = 1'b0;
    txclk = 1'b0;
    c = 0; fin1 = 0;
    for (int k = 1; k <= 400 && fin1 == 0; k++) begin
      txclk = (k % 2 == 0);
      @(negedge clk);
      c = k;
      if (k == 32) check("slow_start_end", {31'd0, sout}, 32'd0);
      if (k == 33) check("slow_bit0", {31'd0, sout}, 32'd1);
      if (txfinished === 1'b1) fin1 = k;
      @(posedge clk); #1;
    end
    check("slow_fin_cycle", fin1, 32'd321);
    txclk = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
